pix_mem_arb: RTL and testbench



---
 rtl/pix_mem_arb_if.sv | 59 +++++
 rtl/pix_mem_arb.sv | 230 +++++++++++++++++++++++
 tb/tb_pix_mem_arb.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pix_mem_arb_if.sv
// ---------------------------------------------------------------------------
// pix_mem_arb_if
//
// Purpose:
//   Bundles every bus-level signal around the pixel RAM read arbiter:
//   both requester handshakes (template fetcher f, search-strip fetcher g),
//   the RAM read port and the busy flag. clk/rst stay outside the bundle.
//
// Modports:
//   slave  - the arbiter's view (takes requests and RAM data, drives grants,
//            returned data, the RAM read port and busy)
//   master - the surroundings' view (requesters plus the RAM itself)
//
// Signals:
//   req_f/req_g       requester wants a beat this cycle
//   addr_f/addr_g     read address, meaningful while req_x is high
//   gnt_f/gnt_g       requester currently owns the RAM port
//   rdata_f/rdata_g   returned pixel, zero unless rvalid_x
//   rvalid_f/rvalid_g one-cycle pulse per returned beat
//   mem_en/mem_addr   RAM read strobe and address
//   mem_rdata         RAM data, RD_LAT cycles after mem_en
//   busy              a beat is being issued or a read is still in flight
// ---------------------------------------------------------------------------
interface pix_mem_arb_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 3
);
    logic              req_f;
    logic [ADDR_W-1:0] addr_f;
    logic              gnt_f;
    logic [DATA_W-1:0] rdata_f;
    logic              rvalid_f;

    logic              req_g;
    logic [ADDR_W-1:0] addr_g;
    logic              gnt_g;
    logic [DATA_W-1:0] rdata_g;
    logic              rvalid_g;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  req_f, addr_f, req_g, addr_g, mem_rdata,
        output gnt_f, rdata_f, rvalid_f,
        output gnt_g, rdata_g, rvalid_g,
        output mem_en, mem_addr, busy
    );

    modport master (
        output req_f, addr_f, req_g, addr_g, mem_rdata,
        input  gnt_f, rdata_f, rvalid_f,
        input  gnt_g, rdata_g, rvalid_g,
        input  mem_en, mem_addr, busy
    );
endinterface

// File: rtl/pix_mem_arb.sv
// ---------------------------------------------------------------------------
// pix_mem_arb
//
// Purpose:
//   Shares the single read port of the pixel RAM between the template (f)
//   window fetcher and the search-strip (g) fetcher. Ownership is handed
//   out in bursts of up to MAX_BURST beats and alternates round-robin when
//   both sides want the port. Read data is steered back to whichever
//   requester issued the beat, RD_LAT cycles later, by a tag pipeline.
//
// Parameters:
//   ADDR_W    pixel RAM address width
//   DATA_W    pixel width
//   RD_LAT    RAM read latency in cycles (1..4)
//   MAX_BURST maximum beats per grant (one template row)
//
// Ports:
//   clk   in   system clock, everything on posedge
//   rst   in   synchronous active-high reset
//   bus   slave modport of pix_mem_arb_if (requests, grants, read return,
//              RAM read port, busy)
//
// Optional build macro ARB_STATS_EN adds three saturating 16-bit counters:
//   stall_f  out  cycles with req_f high and no grant to f
//   stall_g  out  cycles with req_g high and no grant to g
//   beats    out  beats issued to the RAM
// Without the macro these ports do not exist.
// ---------------------------------------------------------------------------
module pix_mem_arb #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 3,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rst,
    pix_mem_arb_if.slave  bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]   stall_f,
    output logic [15:0]   stall_g,
    output logic [15:0]   beats
`endif
);

    // Counter is one bit wider than strictly needed so MAX_BURST=1 still
    // gives a legal non-zero width.
    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN_F,
        OWN_G
    } state_t;

    typedef enum logic {
        OWNER_F = 1'b0,
        OWNER_G = 1'b1
    } owner_t;

    state_t            state;
    state_t            state_nxt;
    owner_t            last_owner;
    owner_t            last_owner_nxt;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  burst_cnt_nxt;

    logic              gnt_f;
    logic              gnt_g;
    logic              beat_f;
    logic              beat_g;
    logic              beat;
    logic [ADDR_W-1:0] addr_sel;

    // Tag pipeline: stage 0 captures the beat, stage RD_LAT-1 lines up with
    // the RAM data. tag_owner bit is 1 for g, 0 for f.
    logic [RD_LAT-1:0] tag_valid;
    logic [RD_LAT-1:0] tag_owner;
    logic              ret_valid;
    logic              ret_g;
    logic [DATA_W-1:0] ret_data;

    // Grants are pure decodes of the registered state, so a requester sees
    // its grant one cycle after the arbitration decision.
    assign gnt_f  = (state == OWN_F);
    assign gnt_g  = (state == OWN_G);
    assign beat_f = gnt_f & bus.req_f;
    assign beat_g = gnt_g & bus.req_g;
    assign beat   = beat_f | beat_g;

    // Address mux: only the address present in the beat cycle reaches the
    // RAM; the port idles at zero otherwise.
    always_comb begin
        addr_sel = '0;
        if (beat_f) begin
            addr_sel = bus.addr_f;
        end else if (beat_g) begin
            addr_sel = bus.addr_g;
        end
    end

    assign bus.gnt_f    = gnt_f;
    assign bus.gnt_g    = gnt_g;
    assign bus.mem_en   = beat;
    assign bus.mem_addr = addr_sel;

    // Arbitration state, round-robin memory and burst length counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= OWNER_G;
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    // Next-state logic. A requester that drops req while owning costs one
    // bubble cycle: the grant is still visible but no beat is issued, and
    // the port moves on at the following edge. A full burst with the other
    // side waiting hands over without a bubble.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        burst_cnt_nxt  = burst_cnt;

        unique case (state)
            IDLE: begin
                if (bus.req_f && bus.req_g) begin
                    state_nxt = (last_owner == OWNER_G) ? OWN_F : OWN_G;
                end else if (bus.req_f) begin
                    state_nxt = OWN_F;
                end else if (bus.req_g) begin
                    state_nxt = OWN_G;
                end
            end

            OWN_F: begin
                if (!bus.req_f) begin
                    state_nxt      = bus.req_g ? OWN_G : IDLE;
                    burst_cnt_nxt  = '0;
                    last_owner_nxt = OWNER_F;
                end else if (burst_cnt == LAST_BEAT) begin
                    burst_cnt_nxt = '0;
                    if (bus.req_g) begin
                        state_nxt      = OWN_G;
                        last_owner_nxt = OWNER_F;
                    end
                end else begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end
            end

            OWN_G: begin
                if (!bus.req_g) begin
                    state_nxt      = bus.req_f ? OWN_F : IDLE;
                    burst_cnt_nxt  = '0;
                    last_owner_nxt = OWNER_G;
                end else if (burst_cnt == LAST_BEAT) begin
                    burst_cnt_nxt = '0;
                    if (bus.req_f) begin
                        state_nxt      = OWN_F;
                        last_owner_nxt = OWNER_G;
                    end
                end else begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tag shift register. Each beat records who issued it; the tag walks
    // alongside the RAM access so data returns to the issuer even if the
    // port has since changed hands. Reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            tag_valid[0] <= beat;
            tag_owner[0] <= beat_g;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
        end
    end

    assign ret_valid = tag_valid[RD_LAT-1];
    assign ret_g     = tag_owner[RD_LAT-1];
    assign ret_data  = bus.mem_rdata;

    // Read return is combinational from the RAM output; the requester that
    // does not own the returning tag sees zero data.
    assign bus.rvalid_f = ret_valid & ~ret_g;
    assign bus.rvalid_g = ret_valid &  ret_g;
    assign bus.rdata_f  = (ret_valid && !ret_g) ? ret_data : '0;
    assign bus.rdata_g  = (ret_valid &&  ret_g) ? ret_data : '0;

    assign bus.busy = beat | (|tag_valid);

`ifdef ARB_STATS_EN
    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_f <= '0;
            stall_g <= '0;
            beats   <= '0;
        end else begin
            if (bus.req_f && !gnt_f && (stall_f != 16'hFFFF)) begin
                stall_f <= stall_f + 16'd1;
            end
            if (bus.req_g && !gnt_g && (stall_g != 16'hFFFF)) begin
                stall_g <= stall_g + 16'd1;
            end
            if (beat && (beats != 16'hFFFF)) begin
                beats <= beats + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pix_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_pix_mem_arb
//
// Directed bench for pix_mem_arb. Three arbiters are built with RD_LAT of
// 1, 2 and 3, each with its own simple RAM model whose content is a fixed
// function of the address. Inputs are applied on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_pix_mem_arb;

    localparam int ADDR_W    = 11;
    localparam int DATA_W    = 3;
    localparam int MAX_BURST = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pix_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
    pix_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();
    pix_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus3 ();

`ifdef ARB_STATS_EN
    logic [15:0] stall_f1, stall_g1, beats1;
    logic [15:0] stall_f2, stall_g2, beats2;
    logic [15:0] stall_f3, stall_g3, beats3;
`endif

    pix_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1), .MAX_BURST(MAX_BURST)) u_lat1 (
        .clk(clk), .rst(rst), .bus(bus1)
`ifdef ARB_STATS_EN
        , .stall_f(stall_f1), .stall_g(stall_g1), .beats(beats1)
`endif
    );

    pix_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2), .MAX_BURST(MAX_BURST)) u_lat2 (
        .clk(clk), .rst(rst), .bus(bus2)
`ifdef ARB_STATS_EN
        , .stall_f(stall_f2), .stall_g(stall_g2), .beats(beats2)
`endif
    );

    pix_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3), .MAX_BURST(MAX_BURST)) u_lat3 (
        .clk(clk), .rst(rst), .bus(bus3)
`ifdef ARB_STATS_EN
        , .stall_f(stall_f3), .stall_g(stall_g3), .beats(beats3)
`endif
    );

    // RAM content: a fixed scramble of the address so neighbouring pixels differ.
    function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
        return a[2:0] ^ a[5:3] ^ 3'b101;
    endfunction

    logic [DATA_W-1:0] rp1 = '0;
    logic [DATA_W-1:0] rp2 [2] = '{default: '0};
    logic [DATA_W-1:0] rp3 [3] = '{default: '0};

    // RAM models with 1, 2 and 3 cycles of read latency.
    always @(posedge clk) begin
        rp1    <= ram_word(bus1.mem_addr);
        rp2[0] <= ram_word(bus2.mem_addr);
        rp2[1] <= rp2[0];
        rp3[0] <= ram_word(bus3.mem_addr);
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    assign bus1.mem_rdata = rp1;
    assign bus2.mem_rdata = rp2[1];
    assign bus3.mem_rdata = rp3[2];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic idle_all;
        bus1.req_f = 1'b0; bus1.req_g = 1'b0; bus1.addr_f = '0; bus1.addr_g = '0;
        bus2.req_f = 1'b0; bus2.req_g = 1'b0; bus2.addr_f = '0; bus2.addr_g = '0;
        bus3.req_f = 1'b0; bus3.req_g = 1'b0; bus3.addr_f = '0; bus3.addr_g = '0;
    endtask

    task automatic do_reset;
        tick;
        rst = 1'b1;
        idle_all;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Outputs of every instance must be quiet while reset is held.
    task automatic test_reset;
        tick;
        rst = 1'b1;
        idle_all;
        tick;
        tick;
        #1;
        total++;
        if ({bus1.gnt_f, bus1.gnt_g, bus1.mem_en, bus1.busy, bus1.rvalid_f, bus1.rvalid_g} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset.lat1 got=%b exp=000000", {bus1.gnt_f, bus1.gnt_g, bus1.mem_en, bus1.busy, bus1.rvalid_f, bus1.rvalid_g});
        end
        total++;
        if ({bus2.gnt_f, bus2.gnt_g, bus2.mem_en, bus2.busy, bus2.rvalid_f, bus2.rvalid_g} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset.lat2 got=%b exp=000000", {bus2.gnt_f, bus2.gnt_g, bus2.mem_en, bus2.busy, bus2.rvalid_f, bus2.rvalid_g});
        end
        total++;
        if ({bus3.gnt_f, bus3.gnt_g, bus3.mem_en, bus3.busy, bus3.rvalid_f, bus3.rvalid_g} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset.lat3 got=%b exp=000000", {bus3.gnt_f, bus3.gnt_g, bus3.mem_en, bus3.busy, bus3.rvalid_f, bus3.rvalid_g});
        end
        total++;
        if ({bus1.mem_addr, bus1.rdata_f, bus1.rdata_g} !== '0) begin
            bad++;
            $display("[TB] FAIL reset.data got addr=%0d rf=%0d rg=%0d exp=0", bus1.mem_addr, bus1.rdata_f, bus1.rdata_g);
        end
        rst = 1'b0;
    endtask

    // f alone reads addresses 0..19; the burst counter wraps without a bubble.
    task automatic test_single_requester;
        logic exp_gnt, exp_en, exp_rv;
        int   pulses;
        pulses = 0;
        do_reset;
        for (int c = 0; c <= 22; c++) begin
            tick;
            bus1.req_f  = (c <= 20);
            bus1.addr_f = ADDR_W'((c > 0) ? c - 1 : 0);
            #1;
            exp_gnt = (c >= 1 && c <= 21);
            exp_en  = (c >= 1 && c <= 20);
            exp_rv  = (c >= 2 && c <= 21);
            total++;
            if ({bus1.gnt_f, bus1.gnt_g} !== {exp_gnt, 1'b0}) begin
                bad++;
                $display("[TB] FAIL single.gnt c=%0d got=%b%b exp=%b0", c, bus1.gnt_f, bus1.gnt_g, exp_gnt);
            end
            total++;
            if (bus1.mem_en !== exp_en) begin
                bad++;
                $display("[TB] FAIL single.mem_en c=%0d got=%b exp=%b", c, bus1.mem_en, exp_en);
            end
            if (exp_en) begin
                total++;
                if (bus1.mem_addr !== ADDR_W'(c - 1)) begin
                    bad++;
                    $display("[TB] FAIL single.mem_addr c=%0d got=%0d exp=%0d", c, bus1.mem_addr, c - 1);
                end
            end
            total++;
            if ({bus1.rvalid_f, bus1.rvalid_g} !== {exp_rv, 1'b0}) begin
                bad++;
                $display("[TB] FAIL single.rvalid c=%0d got=%b%b exp=%b0", c, bus1.rvalid_f, bus1.rvalid_g, exp_rv);
            end
            if (exp_rv) begin
                total++;
                if (bus1.rdata_f !== ram_word(ADDR_W'(c - 2))) begin
                    bad++;
                    $display("[TB] FAIL single.rdata c=%0d got=%0d exp=%0d", c, bus1.rdata_f, ram_word(ADDR_W'(c - 2)));
                end
            end
            if (bus1.rvalid_f === 1'b1) pulses++;
        end
        total++;
        if (pulses != 20) begin
            bad++;
            $display("[TB] FAIL single.pulses got=%0d exp=20", pulses);
        end
        total++;
        if (bus1.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single.busy_end got=%b exp=0", bus1.busy);
        end
    endtask

    // Simultaneous requests out of reset: f 16 beats, g 16 beats, f again.
    task automatic test_tie;
        logic gf, gg, en, rvf, rvg;
        logic [ADDR_W-1:0] ea;
        do_reset;
        for (int c = 0; c <= 34; c++) begin
            tick;
            bus1.req_f  = (c <= 33);
            bus1.req_g  = (c <= 32);
            bus1.addr_f = ADDR_W'(50 + c);
            bus1.addr_g = ADDR_W'(300 + c);
            #1;
            gf  = (c >= 1 && c <= 16) || (c >= 33);
            gg  = (c >= 17 && c <= 32);
            en  = (c >= 1 && c <= 33);
            ea  = gg ? ADDR_W'(300 + c) : ADDR_W'(50 + c);
            rvf = (c >= 2 && c <= 17) || (c == 34);
            rvg = (c >= 18 && c <= 33);
            total++;
            if ({bus1.gnt_f, bus1.gnt_g} !== {gf, gg}) begin
                bad++;
                $display("[TB] FAIL tie.gnt c=%0d got=%b%b exp=%b%b", c, bus1.gnt_f, bus1.gnt_g, gf, gg);
            end
            total++;
            if (bus1.mem_en !== en) begin
                bad++;
                $display("[TB] FAIL tie.mem_en c=%0d got=%b exp=%b", c, bus1.mem_en, en);
            end
            if (en) begin
                total++;
                if (bus1.mem_addr !== ea) begin
                    bad++;
                    $display("[TB] FAIL tie.mem_addr c=%0d got=%0d exp=%0d", c, bus1.mem_addr, ea);
                end
            end
            total++;
            if ({bus1.rvalid_f, bus1.rvalid_g} !== {rvf, rvg}) begin
                bad++;
                $display("[TB] FAIL tie.rvalid c=%0d got=%b%b exp=%b%b", c, bus1.rvalid_f, bus1.rvalid_g, rvf, rvg);
            end
            if (rvg) begin
                total++;
                if ({bus1.rdata_g, bus1.rdata_f} !== {ram_word(ADDR_W'(300 + c - 1)), 3'b000}) begin
                    bad++;
                    $display("[TB] FAIL tie.rdata_g c=%0d got=%0d/%0d exp=%0d/0", c, bus1.rdata_g, bus1.rdata_f, ram_word(ADDR_W'(300 + c - 1)));
                end
            end
        end
    endtask

    // f drops req after 5 beats while g waits: one bubble, then g.
    task automatic test_early_release;
        logic gf, gg, en, rvf, rvg;
        logic [ADDR_W-1:0] ea;
        do_reset;
        for (int c = 0; c <= 8; c++) begin
            tick;
            bus1.req_f  = (c <= 5);
            bus1.req_g  = (c <= 7);
            bus1.addr_f = ADDR_W'(20 + c);
            bus1.addr_g = ADDR_W'(400 + c);
            #1;
            gf  = (c >= 1 && c <= 6);
            gg  = (c >= 7);
            en  = (c >= 1 && c <= 5) || (c == 7);
            ea  = (c == 7) ? ADDR_W'(407) : ADDR_W'(20 + c);
            rvf = (c >= 2 && c <= 6);
            rvg = (c == 8);
            total++;
            if ({bus1.gnt_f, bus1.gnt_g, bus1.mem_en} !== {gf, gg, en}) begin
                bad++;
                $display("[TB] FAIL early.gnt_en c=%0d got=%b%b%b exp=%b%b%b", c, bus1.gnt_f, bus1.gnt_g, bus1.mem_en, gf, gg, en);
            end
            if (en) begin
                total++;
                if (bus1.mem_addr !== ea) begin
                    bad++;
                    $display("[TB] FAIL early.mem_addr c=%0d got=%0d exp=%0d", c, bus1.mem_addr, ea);
                end
            end
            total++;
            if ({bus1.rvalid_f, bus1.rvalid_g} !== {rvf, rvg}) begin
                bad++;
                $display("[TB] FAIL early.rvalid c=%0d got=%b%b exp=%b%b", c, bus1.rvalid_f, bus1.rvalid_g, rvf, rvg);
            end
            if (rvf) begin
                total++;
                if (bus1.rdata_f !== ram_word(ADDR_W'(20 + c - 1))) begin
                    bad++;
                    $display("[TB] FAIL early.rdata_f c=%0d got=%0d exp=%0d", c, bus1.rdata_f, ram_word(ADDR_W'(20 + c - 1)));
                end
            end
            if (rvg) begin
                total++;
                if (bus1.rdata_g !== ram_word(ADDR_W'(407))) begin
                    bad++;
                    $display("[TB] FAIL early.rdata_g c=%0d got=%0d exp=%0d", c, bus1.rdata_g, ram_word(ADDR_W'(407)));
                end
            end
        end
    endtask

    // RD_LAT=3: two f reads still in flight when g takes over.
    task automatic test_latency;
        logic gf, gg, en, rvf, rvg, bz;
        logic [ADDR_W-1:0] ea;
        do_reset;
        for (int c = 0; c <= 10; c++) begin
            tick;
            bus3.req_f  = (c <= 2);
            bus3.req_g  = (c <= 6);
            bus3.addr_f = ADDR_W'(10 + c);
            bus3.addr_g = ADDR_W'(40 + c);
            #1;
            gf  = (c >= 1 && c <= 3);
            gg  = (c >= 4 && c <= 7);
            en  = (c == 1) || (c == 2) || (c >= 4 && c <= 6);
            ea  = (c <= 2) ? ADDR_W'(10 + c) : ADDR_W'(40 + c);
            rvf = (c == 4) || (c == 5);
            rvg = (c >= 7 && c <= 9);
            bz  = (c >= 1 && c <= 9);
            total++;
            if ({bus3.gnt_f, bus3.gnt_g, bus3.mem_en, bus3.busy} !== {gf, gg, en, bz}) begin
                bad++;
                $display("[TB] FAIL lat3.ctrl c=%0d got=%b%b%b%b exp=%b%b%b%b", c, bus3.gnt_f, bus3.gnt_g, bus3.mem_en, bus3.busy, gf, gg, en, bz);
            end
            if (en) begin
                total++;
                if (bus3.mem_addr !== ea) begin
                    bad++;
                    $display("[TB] FAIL lat3.mem_addr c=%0d got=%0d exp=%0d", c, bus3.mem_addr, ea);
                end
            end
            total++;
            if ({bus3.rvalid_f, bus3.rvalid_g} !== {rvf, rvg}) begin
                bad++;
                $display("[TB] FAIL lat3.rvalid c=%0d got=%b%b exp=%b%b", c, bus3.rvalid_f, bus3.rvalid_g, rvf, rvg);
            end
            if (rvf) begin
                total++;
                if (bus3.rdata_f !== ram_word(ADDR_W'(10 + c - 3))) begin
                    bad++;
                    $display("[TB] FAIL lat3.rdata_f c=%0d got=%0d exp=%0d", c, bus3.rdata_f, ram_word(ADDR_W'(10 + c - 3)));
                end
            end
            if (rvg) begin
                total++;
                if (bus3.rdata_g !== ram_word(ADDR_W'(40 + c - 3))) begin
                    bad++;
                    $display("[TB] FAIL lat3.rdata_g c=%0d got=%0d exp=%0d", c, bus3.rdata_g, ram_word(ADDR_W'(40 + c - 3)));
                end
            end
        end
    endtask

    // RD_LAT=2: reset pulse in the cycle of f's 7th beat drops in-flight reads.
    task automatic test_reset_mid_burst;
        logic gf, en, rvf, bz;
        do_reset;
        for (int c = 0; c <= 11; c++) begin
            tick;
            rst         = (c == 7);
            bus2.req_f  = 1'b1;
            bus2.req_g  = (c >= 8);
            bus2.addr_f = ADDR_W'(60 + c);
            bus2.addr_g = ADDR_W'(500 + c);
            #1;
            gf  = (c >= 1 && c <= 7) || (c >= 9);
            en  = gf;
            rvf = (c >= 3 && c <= 7) || (c == 11);
            bz  = (c >= 1) && (c != 8);
            total++;
            if ({bus2.gnt_f, bus2.gnt_g, bus2.mem_en, bus2.busy} !== {gf, 1'b0, en, bz}) begin
                bad++;
                $display("[TB] FAIL rstmid.ctrl c=%0d got=%b%b%b%b exp=%b0%b%b", c, bus2.gnt_f, bus2.gnt_g, bus2.mem_en, bus2.busy, gf, en, bz);
            end
            total++;
            if ({bus2.rvalid_f, bus2.rvalid_g} !== {rvf, 1'b0}) begin
                bad++;
                $display("[TB] FAIL rstmid.rvalid c=%0d got=%b%b exp=%b0", c, bus2.rvalid_f, bus2.rvalid_g, rvf);
            end
            if (rvf) begin
                total++;
                if (bus2.rdata_f !== ram_word(ADDR_W'(60 + c - 2))) begin
                    bad++;
                    $display("[TB] FAIL rstmid.rdata_f c=%0d got=%0d exp=%0d", c, bus2.rdata_f, ram_word(ADDR_W'(60 + c - 2)));
                end
            end
        end
        rst = 1'b0;
    endtask

`ifdef ARB_STATS_EN
    // f holds the port for a full burst while g requests throughout.
    task automatic test_stats;
        do_reset;
        for (int c = 0; c <= 17; c++) begin
            tick;
            bus1.req_f  = (c <= 16);
            bus1.req_g  = 1'b1;
            bus1.addr_f = ADDR_W'(c);
            bus1.addr_g = ADDR_W'(700 + c);
            #1;
            if (c == 0) begin
                total++;
                if ({stall_f1, stall_g1, beats1} !== 48'd0) begin
                    bad++;
                    $display("[TB] FAIL stats.clear got=%0d/%0d/%0d exp=0/0/0", stall_f1, stall_g1, beats1);
                end
            end
            if (c == 17) begin
                total++;
                if (stall_g1 !== 16'd17) begin
                    bad++;
                    $display("[TB] FAIL stats.stall_g got=%0d exp=17", stall_g1);
                end
                total++;
                if (beats1 !== 16'd16) begin
                    bad++;
                    $display("[TB] FAIL stats.beats got=%0d exp=16", beats1);
                end
                total++;
                if (stall_f1 !== 16'd1) begin
                    bad++;
                    $display("[TB] FAIL stats.stall_f got=%0d exp=1", stall_f1);
                end
            end
        end
    endtask
`endif

    initial begin
        idle_all;
        rst = 1'b0;
        test_reset;
        test_single_requester;
        test_tie;
        test_early_release;
        test_latency;
        test_reset_mid_burst;
`ifdef ARB_STATS_EN
        test_stats;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
